// File: rtl/gmac_pkg.sv
// ---------------------------------------------------------------------------
// gmac_pkg
//   Shared definitions for the GMAC transmit arbiter:
//   - NUM_CH       : number of frame sources sharing the MAC TX path
//   - ST_*         : arbiter FSM state encoding
//   - onehot_idx() : converts a one-hot channel vector to its channel index
// ---------------------------------------------------------------------------
package gmac_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_XFER     = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  // Index of the set bit in a one-hot channel vector (channel 0 when none set).
  function automatic logic [1:0] onehot_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3
//   Combinational three-way round-robin picker. The search starts at the
//   channel after the last one served and wraps around.
//   Ports:
//     req  [2:0] in   request vector, bit N = channel N wants the path
//     last [1:0] in   channel served last (3 is treated like 2)
//     gnt  [2:0] out  one-hot winner, all zero when nobody requests
//     any        out  at least one request is present
// ---------------------------------------------------------------------------
module rr_pick3
  import gmac_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic [NUM_CH-1:0] gnt,
  output logic              any
);

  // Priority search rotated by the last-served pointer.
  always_comb begin
    gnt = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/gmac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// gmac_tx_arbiter
//   Shares the GMAC transmit path between three frame sources. One frame per
//   grant, round-robin order, registered byte forwarding, inter-frame gap,
//   SoF timeout and maximum-length abort.
//   Ports:
//     CLK, RST                 clock, asynchronous active-high reset
//     ValInN/SoFInN/EoFInN     channel N byte valid / first / last (N=0..2)
//     ReqInN                   channel N requests the transmitter
//     DataInN [7:0]            channel N byte
//     MacReady                 MAC can accept a new frame (sampled in IDLE)
//     ReqConfirm [2:0]         one-hot grant
//     ValOut/SoFOut/EoFOut     forwarded byte qualifiers (EoFOut alone = abort)
//     DataOut [7:0]            forwarded byte, holds while ValOut=0
//     ErrOut                   one-cycle pulse on timeout or abort
// ---------------------------------------------------------------------------
module gmac_tx_arbiter
  import gmac_pkg::*;
#(
  parameter int IFG_CYCLES  = 12,
  parameter int SOF_TIMEOUT = 255,
  parameter int MAX_LEN     = 1500
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ValIn0,
  input  logic              SoFIn0,
  input  logic              EoFIn0,
  input  logic              ReqIn0,
  input  logic [7:0]        DataIn0,
  input  logic              ValIn1,
  input  logic              SoFIn1,
  input  logic              EoFIn1,
  input  logic              ReqIn1,
  input  logic [7:0]        DataIn1,
  input  logic              ValIn2,
  input  logic              SoFIn2,
  input  logic              EoFIn2,
  input  logic              ReqIn2,
  input  logic [7:0]        DataIn2,
  input  logic              MacReady,
  output logic [NUM_CH-1:0] ReqConfirm,
  output logic              ValOut,
  output logic              SoFOut,
  output logic              EoFOut,
  output logic [7:0]        DataOut,
  output logic              ErrOut
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int TMR_W = $clog2(SOF_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(SOF_TIMEOUT);
  // Timeout fires on the cycle that completes SOF_TIMEOUT granted cycles.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SOF_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [1:0]        ptr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;

  logic [NUM_CH-1:0] req_vec;
  logic [NUM_CH-1:0] gnt;
  logic              any_req;

  logic              own_val;
  logic              own_sof;
  logic              own_eof;
  logic              own_req;
  logic [7:0]        own_data;

  logic              start_grant;
  logic              ws_drop;
  logic              ws_sof;
  logic              ws_tmo;
  logic              x_abort;
  logic              x_beat;
  logic              gap_done;

  logic [NUM_CH-1:0] conf_next;
  logic              val_next;
  logic              sof_next;
  logic              eof_next;
  logic              err_next;
  logic [7:0]        data_next;

  assign req_vec = {ReqIn2, ReqIn1, ReqIn0};

  rr_pick3 u_pick (
    .req  (req_vec),
    .last (ptr),
    .gnt  (gnt),
    .any  (any_req)
  );

  // Select the current owner's inputs; everyone else is ignored.
  always_comb begin
    own_val  = 1'b0;
    own_sof  = 1'b0;
    own_eof  = 1'b0;
    own_req  = 1'b0;
    own_data = 8'h00;
    case (ptr)
      2'd0: begin
        own_val = ValIn0; own_sof = SoFIn0; own_eof = EoFIn0;
        own_req = ReqIn0; own_data = DataIn0;
      end
      2'd1: begin
        own_val = ValIn1; own_sof = SoFIn1; own_eof = EoFIn1;
        own_req = ReqIn1; own_data = DataIn1;
      end
      default: begin
        own_val = ValIn2; own_sof = SoFIn2; own_eof = EoFIn2;
        own_req = ReqIn2; own_data = DataIn2;
      end
    endcase
  end

  // A dropped request while waiting takes priority over a SoF in the same cycle.
  assign start_grant = (state == ST_IDLE) && MacReady && any_req;
  assign ws_drop     = (state == ST_WAIT_SOF) && !own_req;
  assign ws_sof      = (state == ST_WAIT_SOF) && own_req && own_val && own_sof;
  assign ws_tmo      = (state == ST_WAIT_SOF) && own_req && !ws_sof && (timer == TMR_LAST);
  assign x_abort     = (state == ST_XFER) && own_val && (own_sof || (byte_cnt == CNT_MAX));
  assign x_beat      = (state == ST_XFER) && own_val && !x_abort;
  assign gap_done    = (state == ST_GAP) && (gap_cnt == GAP_LAST);

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_grant) state_next = ST_WAIT_SOF;
        else             state_next = ST_IDLE;
      end
      ST_WAIT_SOF: begin
        if (ws_drop)     state_next = ST_IDLE;
        else if (ws_sof) state_next = own_eof ? ST_GAP : ST_XFER;
        else if (ws_tmo) state_next = ST_GAP;
        else             state_next = ST_WAIT_SOF;
      end
      ST_XFER: begin
        if (x_abort)                state_next = ST_GAP;
        else if (x_beat && own_eof) state_next = ST_GAP;
        else                        state_next = ST_XFER;
      end
      ST_GAP: begin
        if (gap_done) state_next = ST_IDLE;
        else          state_next = ST_GAP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    conf_next = ReqConfirm;
    val_next  = 1'b0;
    sof_next  = 1'b0;
    eof_next  = 1'b0;
    err_next  = 1'b0;
    data_next = DataOut;
    case (state)
      ST_IDLE: begin
        if (start_grant) conf_next = gnt;
        else             conf_next = 3'b000;
      end
      ST_WAIT_SOF: begin
        if (ws_drop) begin
          conf_next = 3'b000;
        end else if (ws_sof) begin
          val_next  = 1'b1;
          sof_next  = 1'b1;
          eof_next  = own_eof;
          data_next = own_data;
          if (own_eof) conf_next = 3'b000;
          else         conf_next = ReqConfirm;
        end else if (ws_tmo) begin
          conf_next = 3'b000;
          err_next  = 1'b1;
        end else begin
          conf_next = ReqConfirm;
        end
      end
      ST_XFER: begin
        if (x_abort) begin
          // Abort terminator: EoF without a valid byte.
          conf_next = 3'b000;
          eof_next  = 1'b1;
          err_next  = 1'b1;
        end else if (x_beat) begin
          val_next  = 1'b1;
          eof_next  = own_eof;
          data_next = own_data;
          if (own_eof) conf_next = 3'b000;
          else         conf_next = ReqConfirm;
        end else begin
          conf_next = ReqConfirm;
        end
      end
      ST_GAP:  conf_next = 3'b000;
      default: conf_next = 3'b000;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ReqConfirm <= 3'b000;
      ValOut     <= 1'b0;
      SoFOut     <= 1'b0;
      EoFOut     <= 1'b0;
      ErrOut     <= 1'b0;
      DataOut    <= 8'h00;
    end else begin
      ReqConfirm <= conf_next;
      ValOut     <= val_next;
      SoFOut     <= sof_next;
      EoFOut     <= eof_next;
      ErrOut     <= err_next;
      DataOut    <= data_next;
    end
  end

  // Last-served pointer, byte counter, SoF timer and gap counter (all saturating).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr      <= 2'd2;
      byte_cnt <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      if (start_grant) ptr <= onehot_idx(gnt);

      if (state == ST_WAIT_SOF) begin
        timer <= (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
      end else begin
        timer <= '0;
      end

      if (ws_sof) begin
        byte_cnt <= CNT_W'(1);
      end else if (x_beat) begin
        byte_cnt <= (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + CNT_W'(1);
      end

      if (state == ST_GAP && !gap_done) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gmac_tx_arbiter.sv
module tb_gmac_tx_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] val = 3'b000;
  logic [2:0] sof = 3'b000;
  logic [2:0] eof = 3'b000;
  logic [2:0] req = 3'b000;
  logic [7:0] din [3];
  logic       MacReady = 1'b0;
  logic [2:0] ReqConfirm;
  logic       ValOut, SoFOut, EoFOut, ErrOut;
  logic [7:0] DataOut;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] conf;
    logic       v;
    logic       s;
    logic       e;
    logic       err;
    logic [7:0] d;
  } obs_t;

  obs_t       log_q [$];
  logic [7:0] pat_d [0:1599];
  logic       pat_s [0:1599];
  logic       pat_e [0:1599];

  always #5 CLK = ~CLK;

  gmac_tx_arbiter dut (
    .CLK(CLK), .RST(RST),
    .ValIn0(val[0]), .SoFIn0(sof[0]), .EoFIn0(eof[0]), .ReqIn0(req[0]), .DataIn0(din[0]),
    .ValIn1(val[1]), .SoFIn1(sof[1]), .EoFIn1(eof[1]), .ReqIn1(req[1]), .DataIn1(din[1]),
    .ValIn2(val[2]), .SoFIn2(sof[2]), .EoFIn2(eof[2]), .ReqIn2(req[2]), .DataIn2(din[2]),
    .MacReady(MacReady), .ReqConfirm(ReqConfirm), .ValOut(ValOut), .SoFOut(SoFOut),
    .EoFOut(EoFOut), .DataOut(DataOut), .ErrOut(ErrOut)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives n beats from the pattern arrays on channel ch and logs the output
  // observed one clock after each beat. Starts and ends on a falling edge.
  task automatic drive_frame(input int ch, input int n);
    log_q.delete();
    for (int i = 0; i < n; i++) begin
      val[ch] = 1'b1; sof[ch] = pat_s[i]; eof[ch] = pat_e[i]; din[ch] = pat_d[i];
      @(negedge CLK);
      log_q.push_back(obs_t'{ReqConfirm, ValOut, SoFOut, EoFOut, ErrOut, DataOut});
    end
    val[ch] = 1'b0; sof[ch] = 1'b0; eof[ch] = 1'b0;
  endtask

  // Advances falling edges until a grant is visible (bounded); n = edges advanced.
  task automatic wait_grant(output int n);
    n = 0;
    while (ReqConfirm == 3'b000 && n < 200) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset();
    din[0] = 8'h00; din[1] = 8'h00; din[2] = 8'h00;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (ReqConfirm !== 3'b000) begin errors++; $display("FAIL reset_conf: got %b want 000", ReqConfirm); end
    checks++; if (ValOut !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", ValOut); end
    checks++; if ({SoFOut, EoFOut, ErrOut} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {SoFOut, EoFOut, ErrOut}); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", DataOut); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_round_robin();
    int n, ch, nv;
    MacReady = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      ch = k % 3;
      wait_grant(n);
      checks++; if (ReqConfirm !== (3'b001 << ch)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, ReqConfirm, 3'b001 << ch); end
      checks++; if (!$onehot(ReqConfirm)) begin errors++; $display("FAIL rr_onehot%0d: got %b want one-hot", k, ReqConfirm); end
      if (k > 0) begin
        checks++; if (n - 1 < 12) begin errors++; $display("FAIL rr_gap%0d: got %0d idle cycles want >=12", k, n - 1); end
      end
      for (int i = 0; i < 4; i++) begin
        pat_d[i] = 8'(16 * ch + i + 1); pat_s[i] = (i == 0); pat_e[i] = (i == 3);
      end
      drive_frame(ch, 4);
      nv = 0;
      for (int j = 0; j < 4; j++) if (log_q[j].v === 1'b1 && log_q[j].d === pat_d[j]) nv++;
      checks++; if (nv != 4) begin errors++; $display("FAIL rr_frame%0d: got %0d good beats want 4", k, nv); end
    end
  endtask

  task automatic test_frame_ch1();
    int n;
    obs_t exp_o [3];
    req = 3'b010;
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b010) begin errors++; $display("FAIL ch1_grant: got %b want 010", ReqConfirm); end
    pat_d[0] = 8'h11; pat_s[0] = 1'b1; pat_e[0] = 1'b0;
    pat_d[1] = 8'h22; pat_s[1] = 1'b0; pat_e[1] = 1'b0;
    pat_d[2] = 8'h33; pat_s[2] = 1'b0; pat_e[2] = 1'b1;
    exp_o[0] = obs_t'{3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11};
    exp_o[1] = obs_t'{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22};
    exp_o[2] = obs_t'{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33};
    drive_frame(1, 3);
    req = 3'b000;
    for (int j = 0; j < 3; j++) begin
      checks++; if (log_q[j] !== exp_o[j]) begin errors++; $display("FAIL ch1_beat%0d: got %h want %h", j, log_q[j], exp_o[j]); end
    end
  endtask

  task automatic test_sof_timeout();
    int n, hi, extra;
    logic saw_val;
    req = 3'b100;
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b100) begin errors++; $display("FAIL tmo_grant: got %b want 100", ReqConfirm); end
    hi = 0; saw_val = 1'b0;
    while (ReqConfirm == 3'b100 && hi < 400) begin
      if (ValOut) saw_val = 1'b1;
      hi++;
      @(negedge CLK);
    end
    checks++; if (hi != 255) begin errors++; $display("FAIL tmo_len: got %0d granted cycles want 255", hi); end
    checks++; if ({ValOut, EoFOut, ErrOut} !== 3'b001) begin errors++; $display("FAIL tmo_err: got val/eof/err %b want 001", {ValOut, EoFOut, ErrOut}); end
    req = 3'b000;
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ErrOut) extra++;
      if (ValOut) saw_val = 1'b1;
    end
    checks++; if (extra != 0 || saw_val !== 1'b0) begin errors++; $display("FAIL tmo_quiet: got %0d extra err, val seen %b want 0,0", extra, saw_val); end
  endtask

  task automatic test_max_len();
    int n, bad;
    obs_t e;
    req = 3'b001;
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b001) begin errors++; $display("FAIL max_grant: got %b want 001", ReqConfirm); end
    for (int i = 0; i < 1501; i++) begin
      pat_d[i] = 8'(i * 7 + 3); pat_s[i] = (i == 0); pat_e[i] = (i == 1500);
    end
    drive_frame(0, 1501);
    req = 3'b000;
    bad = 0;
    for (int j = 0; j < 1500; j++) begin
      e = obs_t'{3'b001, 1'b1, (j == 0), 1'b0, 1'b0, pat_d[j]};
      if (log_q[j] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL max_body: got %0d bad beats want 0", bad); end
    e = obs_t'{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, pat_d[1499]};
    checks++; if (log_q[1500] !== e) begin errors++; $display("FAIL max_abort: got %h want %h", log_q[1500], e); end
  endtask

  task automatic test_sof_abort();
    int n;
    obs_t exp_o [3];
    req = 3'b110;
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b010) begin errors++; $display("FAIL ab_grant: got %b want 010", ReqConfirm); end
    pat_d[0] = 8'hA0; pat_s[0] = 1'b1; pat_e[0] = 1'b0;
    pat_d[1] = 8'hA1; pat_s[1] = 1'b0; pat_e[1] = 1'b0;
    pat_d[2] = 8'hA2; pat_s[2] = 1'b1; pat_e[2] = 1'b0;
    exp_o[0] = obs_t'{3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0};
    exp_o[1] = obs_t'{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1};
    exp_o[2] = obs_t'{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1};
    drive_frame(1, 3);
    req[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++; if (log_q[j] !== exp_o[j]) begin errors++; $display("FAIL ab_beat%0d: got %h want %h", j, log_q[j], exp_o[j]); end
    end
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b100) begin errors++; $display("FAIL ab_next: got %b want 100", ReqConfirm); end
    checks++; if (n - 1 < 12) begin errors++; $display("FAIL ab_gap: got %0d idle cycles want >=12", n - 1); end
    req[2] = 1'b0;
    MacReady = 1'b0;
    @(negedge CLK);
    checks++; if ({ReqConfirm, ValOut, ErrOut} !== 5'b00000) begin errors++; $display("FAIL drop_req: got conf/val/err %b want 00000", {ReqConfirm, ValOut, ErrOut}); end
  endtask

  task automatic test_mac_ready();
    int bad;
    req = 3'b001;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ReqConfirm !== 3'b000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mr_hold: got %0d granted cycles want 0", bad); end
    MacReady = 1'b1;
    @(negedge CLK);
    checks++; if (ReqConfirm !== 3'b001) begin errors++; $display("FAIL mr_grant: got %b want 001", ReqConfirm); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    val[0] = 1'b1; sof[0] = 1'b1; din[0] = 8'hA5;
    @(negedge CLK);
    sof[0] = 1'b0; din[0] = 8'h5A;
    @(negedge CLK);
    checks++; if (ValOut !== 1'b1 || DataOut !== 8'h5A) begin errors++; $display("FAIL rst_pre: got val %b data %h want 1 5a", ValOut, DataOut); end
    req = 3'b111;
    #2 RST = 1'b1;
    #1;
    checks++; if ({ReqConfirm, ValOut, SoFOut, EoFOut, ErrOut, DataOut} !== 15'h0000) begin
      errors++; $display("FAIL rst_async: got %h want 0000", {ReqConfirm, ValOut, SoFOut, EoFOut, ErrOut, DataOut});
    end
    val[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    wait_grant(n);
    checks++; if (ReqConfirm !== 3'b001) begin errors++; $display("FAIL rst_first: got %b want 001", ReqConfirm); end
    req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_frame_ch1();
    test_sof_timeout();
    test_max_len();
    test_sof_abort();
    test_mac_ready();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
